// File: rtl/booth_mult_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller.
// Holds the state encodings, the default operand/counter widths shared with
// the multiplier datapath, the strobe bundle and the Moore output decoder.
package booth_mult_ctrl_pkg;

    localparam int unsigned BOOTH_WIDTH = 8;
    localparam int unsigned BOOTH_CNT_W = 4;
    localparam int unsigned STATE_W     = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_ARITH = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Datapath strobe bundle driven by the controller
    typedef struct packed {
        logic ld_m;
        logic ld_q;
        logic clr_a;
        logic clr_qm1;
        logic ld_a;
        logic sub;
        logic shift;
        logic busy;
        logic done;
    } ctrl_out_t;

    // Moore decode of a state plus the latched add/sub select
    function automatic ctrl_out_t decode_outputs(input state_e s, input logic op_sub);
        ctrl_out_t o;
        o = '0;
        case (s)
            ST_INIT: begin
                o.ld_m    = 1'b1;
                o.ld_q    = 1'b1;
                o.clr_a   = 1'b1;
                o.clr_qm1 = 1'b1;
                o.busy    = 1'b1;
            end
            ST_EVAL:  o.busy = 1'b1;
            ST_ARITH: begin
                o.ld_a = 1'b1;
                o.sub  = op_sub;
                o.busy = 1'b1;
            end
            ST_SHIFT: begin
                o.shift = 1'b1;
                o.busy  = 1'b1;
            end
            ST_DONE: begin
                o.done = 1'b1;
                o.busy = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Handshake/strobe bundle between the Booth controller and its datapath.
// master: controller side (samples go/q0/qm1, drives strobes, state, cnt).
// slave:  datapath / requester side.
interface booth_mult_ctrl_if
    import booth_mult_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = BOOTH_CNT_W
) ();

    logic               go;
    logic               q0;
    logic               qm1;
    logic               ld_m;
    logic               ld_q;
    logic               clr_a;
    logic               clr_qm1;
    logic               ld_a;
    logic               sub;
    logic               shift;
    logic               busy;
    logic               done;
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   cnt;

    modport master (
        input  go, q0, qm1,
        output ld_m, ld_q, clr_a, clr_qm1, ld_a, sub, shift, busy, done, state, cnt
    );

    modport slave (
        output go, q0, qm1,
        input  ld_m, ld_q, clr_a, clr_qm1, ld_a, sub, shift, busy, done, state, cnt
    );

endinterface

// File: rtl/booth_bit_counter.sv
// Loadable down-counter tracking remaining Booth iterations.
// Ports: clk, rst (sync, active-high), load_i/load_val_i (parallel load),
//        dec_i (decrement by one), cnt_o (current value), is_one_o (cnt_o == 1).
// The decrementer is a ripple-borrow chain of half-subtractor cells.
module booth_bit_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             is_one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] dec_val;
    logic [CNT_W-1:0] borrow;

    assign borrow[0] = 1'b1;

    // Half-subtractor cell per bit: diff = a ^ bin, bout = ~a & bin
    for (genvar i = 0; i < CNT_W; i++) begin : g_dec
        assign dec_val[i] = cnt_q[i] ^ borrow[i];
        if (i < CNT_W - 1) begin : g_borrow
            assign borrow[i+1] = ~cnt_q[i] & borrow[i];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = dec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign is_one_o = cnt_q[0] & ~(|cnt_q[CNT_W-1:1]);

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencing controller for the radix-2 Booth sequential multiplier.
// Ports: clk, rst (sync, active-high), bus (booth_mult_ctrl_if.master):
//   go/q0/qm1 in; ld_m, ld_q, clr_a, clr_qm1, ld_a, sub, shift, busy, done,
//   state (debug) and cnt (remaining iterations) out.
// Strobes are registered from the decoded next state, so they line up with
// the state register and have no combinational path from any input.
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = BOOTH_WIDTH,
    parameter int unsigned CNT_W = BOOTH_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_mult_ctrl_if.master     bus
);

    state_e     state_q;
    state_e     state_d;
    logic       op_sub_q;
    logic       op_sub_d;
    ctrl_out_t  out_q;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_is_one;
    logic [CNT_W-1:0] cnt_val;

    booth_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(WIDTH)),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .is_one_o   (cnt_is_one)
    );

    // Next-state logic and counter control
    always_comb begin
        state_d  = state_q;
        op_sub_d = op_sub_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                cnt_load = 1'b1;
                state_d  = ST_EVAL;
            end
            ST_EVAL: begin
                // Booth pair {Q0,Q-1}: 10 -> subtract, 01 -> add, else shift only
                case ({bus.q0, bus.qm1})
                    2'b10: begin
                        op_sub_d = 1'b1;
                        state_d  = ST_ARITH;
                    end
                    2'b01: begin
                        op_sub_d = 1'b0;
                        state_d  = ST_ARITH;
                    end
                    default: state_d = ST_SHIFT;
                endcase
            end
            ST_ARITH: state_d = ST_SHIFT;
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                state_d = cnt_is_one ? ST_DONE : ST_EVAL;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, op select and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_sub_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_sub_q <= op_sub_d;
            out_q    <= decode_outputs(state_d, op_sub_d);
        end
    end

    assign bus.ld_m    = out_q.ld_m;
    assign bus.ld_q    = out_q.ld_q;
    assign bus.clr_a   = out_q.clr_a;
    assign bus.clr_qm1 = out_q.clr_qm1;
    assign bus.ld_a    = out_q.ld_a;
    assign bus.sub     = out_q.sub;
    assign bus.shift   = out_q.shift;
    assign bus.busy    = out_q.busy;
    assign bus.done    = out_q.done;
    assign bus.state   = state_q;
    assign bus.cnt     = cnt_val;

endmodule

// File: doc/booth_mult_ctrl.md
Name: booth_mult_ctrl

Overview:
Sequencing controller for the team's radix-2 Booth sequential multiplier datapath (A/Q/M registers, Q-1 flip-flop, shared add/sub unit). It accepts a one-cycle go request and emits load, clear, add/sub-select and shift strobes once per multiplier bit. It raises done when the product in {A,Q} is valid. The block has no arithmetic datapath and owns only its state register and bit counter.

Parameters:
WIDTH, 8, operand width in bits; the number of Booth iterations.
CNT_W, 4, bit counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
go  input  1  start request; sampled only in IDLE.
q0  input  1  datapath Q[0].
qm1  input  1  datapath Q-1 bit.
ld_m  output  1  load multiplicand register M.
ld_q  output  1  load multiplier register Q.
clr_a  output  1  clear accumulator A.
clr_qm1  output  1  clear Q-1.
ld_a  output  1  load A with the add/sub result.
sub  output  1  add/sub select: 1 = A-M, 0 = A+M; meaningful only when ld_a=1.
shift  output  1  arithmetic right shift of {A,Q,Q-1}.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when the product is valid.
state  output  3  current state encoding, for debug.
cnt  output  CNT_W  remaining iterations.

Behaviour:
- All outputs are Moore, decoded from the registered state plus the registered op_sub bit. There are no combinational paths from go, q0 or qm1 to the outputs.
- States and encodings: IDLE=0, INIT=1, EVAL=2, ARITH=3, SHIFT=4, DONE=5. Codes 6 and 7 are illegal and go to IDLE on the next edge, with all strobes 0.
- IDLE: all strobes 0; busy=0. If go=1, go to INIT; otherwise stay.
- INIT (1 cycle): ld_m=ld_q=clr_a=clr_qm1=1. cnt<=WIDTH. Go to EVAL.
- EVAL (1 cycle): no strobes. Sample {q0,qm1}:
  - 10: op_sub<=1, go to ARITH.
  - 01: op_sub<=0, go to ARITH.
  - 00 or 11: go to SHIFT.
- ARITH (1 cycle): ld_a=1, sub=op_sub. Go to SHIFT.
- SHIFT (1 cycle): shift=1, cnt<=cnt-1. If cnt==1 go to DONE, else go to EVAL.
- DONE (1 cycle): done=1, busy=1. Go to IDLE.
- Latency from the edge that samples go to the cycle in which done=1: 2 + 2*WIDTH + (number of ARITH passes) cycles.
- go asserted while busy is ignored and is not queued. go held high in IDLE after DONE starts a new operation on the next edge.
- Reset: at the first posedge with rst=1, the next state is IDLE with cnt=0, op_sub=0 and every output 0. Reset mid-operation aborts immediately; no done pulse is produced. rst has priority over all transitions.
- cnt never wraps: it decrements only in SHIFT, and SHIFT is never entered with cnt=0.
- At most one of ld_a, shift, and the INIT strobe group is active in any cycle.

Decomposition:
- Shared header: state encodings, and a default WIDTH/CNT_W pair shared with the multiplier datapath.
- One sub-module, booth_bit_counter: a CNT_W-bit loadable down-counter with load, dec and is_one outputs, built gate-level in the codebase's adder style.
- The next-state logic and the output decode stay in booth_mult_ctrl.

Test Plan:
- rst=1 for 2 cycles with go=1 -> state=0, all outputs 0, cnt=0; after release, state=1 on the next edge.
- Q=0x00, single go pulse -> 8 EVAL/SHIFT pairs, no ld_a; done=1 exactly 18 cycles after the go edge; shift counted 8 times.
- Q=0x01 -> first iteration ARITH with sub=1, second iteration sub=0, the rest shift-only; done at cycle 20.
- Q=0x55 -> ARITH on every iteration with sub alternating 1,0,1,0…; done at cycle 26; ld_a and shift are never asserted together.
- rst pulsed for 1 cycle in state ARITH during the third iteration -> IDLE next edge, no done; a later go with Q=0xFF gives done at cycle 19.
- go pulsed during SHIFT, and go held high through DONE -> the mid-operation go is ignored; back-to-back operations occur with exactly one IDLE cycle between done and INIT.
